// File: rtl/deco_pkg.sv
// Shared widths, FSM encoding and default watchdog limit for the Deco
// framing stage. The bench and the Deco model take their widths from here.
package deco_pkg;

  localparam int DECO_BEAT_W      = 21;
  localparam int DECO_BEATS       = 4;
  localparam int DECO_RES_W       = 5;
  localparam int DECO_FRAME_W     = DECO_BEAT_W * DECO_BEATS;
  localparam int DECO_CNT_W       = 16;
  localparam int DECO_TIMEOUT_CYC = 1024;

  // IDLE: waiting for a frame; LOAD: streaming beats; WAIT: waiting for done.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/deco_frame_feeder_if.sv
// Frame-in and result-out handshakes of deco_frame_feeder, plus the FSM
// state for observation.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high. The source holds valid and data stable
// until that edge; ready may depend combinationally on the sink's state.
interface deco_frame_feeder_if;
  import deco_pkg::*;

  logic                    frm_valid_i;
  logic                    frm_ready_o;
  logic [DECO_FRAME_W-1:0] frm_data_i;
  logic                    res_valid_o;
  logic                    res_ready_i;
  logic [DECO_RES_W-1:0]   res_data_o;
  logic                    res_timeout_o;
  state_t                  dbg_state_o;

  // Feeder side.
  modport master (
    input  frm_valid_i, frm_data_i, res_ready_i,
    output frm_ready_o, res_valid_o, res_data_o, res_timeout_o, dbg_state_o
  );

  // Frame producer / result consumer side.
  modport slave (
    output frm_valid_i, frm_data_i, res_ready_i,
    input  frm_ready_o, res_valid_o, res_data_o, res_timeout_o, dbg_state_o
  );

endinterface

// File: rtl/deco_frame_feeder.sv
// Serialises 84-bit codeword frames into four 21-bit beats for the Deco
// decoder, waits for done (guarded by a watchdog) and hands the decoded
// result downstream through a single-entry result register.
module deco_frame_feeder
  import deco_pkg::*;
#(
  parameter int BEAT_W      = DECO_BEAT_W,
  parameter int BEATS       = DECO_BEATS,
  parameter int RES_W       = DECO_RES_W,
  parameter int TIMEOUT_CYC = DECO_TIMEOUT_CYC
) (
  input  logic                  clk_p_i,
  input  logic                  reset_n_i,
  deco_frame_feeder_if.master   bus,
  output logic                  deco_start_o,
  output logic [BEAT_W-1:0]     deco_data_o,
  input  logic                  deco_done_i,
  input  logic [RES_W-1:0]      deco_res_i,
  output logic [DECO_CNT_W-1:0] frame_cnt_o
);

  localparam int FRAME_W = BEAT_W * BEATS;
  localparam int IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WCNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BEATS - 1);
  localparam logic [WCNT_W-1:0] WCNT_TC  = WCNT_W'(TIMEOUT_CYC - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic [FRAME_W-1:0]      frm_q, frm_d;
  logic                    start_q, start_d;
  logic [BEAT_W-1:0]       data_q, data_d;
  logic                    res_valid_q, res_valid_d;
  logic [RES_W-1:0]        res_data_q, res_data_d;
  logic                    res_to_q, res_to_d;
  logic [DECO_CNT_W-1:0]   cnt_q, cnt_d;

  logic             frm_ready;
  logic             frm_accept;
  logic             res_take;
  logic [IDX_W-1:0] idx_nxt;

  // A frame is only launched when the result slot is empty or is being
  // drained this same edge, so a done pulse always finds room.
  assign frm_ready  = (state_q == ST_IDLE) && (!res_valid_q || bus.res_ready_i);
  assign frm_accept = bus.frm_valid_i && frm_ready;
  assign res_take   = res_valid_q && bus.res_ready_i;
  assign idx_nxt    = idx_q + 1'b1;

  // Next-state and registered-output logic for the IDLE/LOAD/WAIT sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    frm_d       = frm_q;
    start_d     = start_q;
    data_d      = data_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_to_d    = res_to_q;
    cnt_d       = cnt_q;

    if (res_take) begin
      res_valid_d = 1'b0;
      res_data_d  = '0;
      res_to_d    = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (frm_accept) begin
          frm_d   = bus.frm_data_i;
          idx_d   = '0;
          wcnt_d  = '0;
          start_d = 1'b1;
          data_d  = bus.frm_data_i[BEAT_W-1:0];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // done is not looked at until the last beat is on the bus.
        idx_d  = idx_nxt;
        data_d = frm_q[int'(idx_nxt)*BEAT_W +: BEAT_W];
        if (idx_nxt == LAST_IDX) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // done beats the watchdog when both land on the same edge.
        if (deco_done_i || (wcnt_q == WCNT_TC)) begin
          res_valid_d = 1'b1;
          res_data_d  = deco_done_i ? deco_res_i : '0;
          res_to_d    = !deco_done_i;
          cnt_d       = cnt_q + 1'b1;
          start_d     = 1'b0;
          data_d      = '0;
          idx_d       = '0;
          wcnt_d      = '0;
          state_d     = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight frame silently.
  always_ff @(posedge clk_p_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wcnt_q      <= '0;
      frm_q       <= '0;
      start_q     <= 1'b0;
      data_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_to_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      frm_q       <= frm_d;
      start_q     <= start_d;
      data_q      <= data_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_to_q    <= res_to_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.frm_ready_o   = frm_ready;
  assign bus.res_valid_o   = res_valid_q;
  assign bus.res_data_o    = res_data_q;
  assign bus.res_timeout_o = res_to_q;
  assign bus.dbg_state_o   = state_q;
  assign deco_start_o      = start_q;
  assign deco_data_o       = data_q;
  assign frame_cnt_o       = cnt_q;

endmodule

// File: tb/tb_deco_frame_feeder.sv
// Bench for deco_frame_feeder: a long-timeout instance fed by a Deco model
// and checked through a result scoreboard, and a short-timeout instance
// driven directly for the watchdog cases.
module tb_deco_frame_feeder;
  import deco_pkg::*;

  localparam int TO_SHORT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  deco_frame_feeder_if bus1();
  deco_frame_feeder_if bus2();

  logic                   start1, start2;
  logic [DECO_BEAT_W-1:0] data1, data2;
  logic                   done1, done2;
  logic [DECO_RES_W-1:0]  dres1, dres2;
  logic [DECO_CNT_W-1:0]  cnt1, cnt2;

  deco_frame_feeder u_dut (
    .clk_p_i      (clk),
    .reset_n_i    (rst_n),
    .bus          (bus1),
    .deco_start_o (start1),
    .deco_data_o  (data1),
    .deco_done_i  (done1),
    .deco_res_i   (dres1),
    .frame_cnt_o  (cnt1)
  );

  deco_frame_feeder #(.TIMEOUT_CYC(TO_SHORT)) u_dut_to (
    .clk_p_i      (clk),
    .reset_n_i    (rst_n),
    .bus          (bus2),
    .deco_start_o (start2),
    .deco_data_o  (data2),
    .deco_done_i  (done2),
    .deco_res_i   (dres2),
    .frame_cnt_o  (cnt2)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DECO_RES_W:0]   exp_q[$];  // {timeout, data}
  logic [DECO_RES_W-1:0] res_q[$];  // values the Deco model will return

  // ---------------- Deco model for u_dut ----------------
  // done is raised 10 cycles after the 5th consecutive start cycle.
  int   mdl_scnt = 0;
  int   mdl_dly  = 0;
  logic mdl_fire;
  initial begin
    done1 = 1'b0;
    dres1 = '0;
  end
  always @(posedge clk) begin
    mdl_fire = 1'b0;
    if (!rst_n) begin
      mdl_scnt = 0;
      mdl_dly  = 0;
    end else begin
      if (mdl_dly > 0) begin
        mdl_dly--;
        if (mdl_dly == 0) mdl_fire = 1'b1;
      end
      if (start1) begin
        mdl_scnt++;
        if (mdl_scnt == 5) mdl_dly = 10;
      end else begin
        mdl_scnt = 0;
      end
    end
    #1;
    done1 = mdl_fire;
    if (mdl_fire) dres1 = (res_q.size() > 0) ? res_q.pop_front() : '0;
  end

  // ---------------- scoreboard on u_dut results ----------------
  logic [DECO_RES_W:0] sb_exp;
  always @(posedge clk) begin
    if (rst_n && bus1.res_valid_o && bus1.res_ready_i) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: got timeout=%0b data=%b, required no result",
                 bus1.res_timeout_o, bus1.res_data_o);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({bus1.res_timeout_o, bus1.res_data_o} !== sb_exp) begin
          tests_failed++;
          $display("FAIL sb_result: got timeout=%0b data=%b, required timeout=%0b data=%b",
                   bus1.res_timeout_o, bus1.res_data_o, sb_exp[DECO_RES_W], sb_exp[DECO_RES_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    bus1.frm_valid_i = 1'b0; bus1.frm_data_i = '0; bus1.res_ready_i = 1'b1;
    bus2.frm_valid_i = 1'b0; bus2.frm_data_i = '0; bus2.res_ready_i = 1'b1;
    done2 = 1'b0; dres2 = '0;
    res_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Offer a frame to u_dut; gap counts start-low samples seen before accept.
  task automatic send_frame1(input logic [DECO_FRAME_W-1:0] f, output int gap, output bit ok);
    gap = 0; ok = 1'b0;
    bus1.frm_valid_i = 1'b1;
    bus1.frm_data_i  = f;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!start1) gap++;
      if (bus1.frm_ready_o) begin ok = 1'b1; break; end
    end
    if (ok) @(posedge clk);
    #1 bus1.frm_valid_i = 1'b0;
  endtask

  task automatic send_frame2(input logic [DECO_FRAME_W-1:0] f, output bit ok);
    ok = 1'b0;
    bus2.frm_valid_i = 1'b1;
    bus2.frm_data_i  = f;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus2.frm_ready_o) begin ok = 1'b1; break; end
    end
    if (ok) @(posedge clk);
    #1 bus2.frm_valid_i = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_res1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus1.res_valid_o) begin ok = 1'b1; break; end
    end
  endtask

  function automatic logic [DECO_FRAME_W-1:0] rand_frame();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[DECO_FRAME_W-1:0];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus1.frm_valid_i = 1'b0; bus1.frm_data_i = '0; bus1.res_ready_i = 1'b0;
    bus2.frm_valid_i = 1'b0; bus2.frm_data_i = '0; bus2.res_ready_i = 1'b0;
    done2 = 1'b0; dres2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({start1, data1, bus1.res_valid_o, bus1.res_data_o, bus1.res_timeout_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got start=%0b data=%h rv=%0b rd=%b to=%0b, required all 0",
               start1, data1, bus1.res_valid_o, bus1.res_data_o, bus1.res_timeout_o);
    end
    tests_run++;
    if (bus1.frm_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_frm_ready: got %0b, required 1", bus1.frm_ready_o);
    end
    tests_run++;
    if (cnt1 !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_frame_cnt: got %0d, required 0", cnt1);
    end
    tests_run++;
    if (bus1.dbg_state_o !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d, required %0d", bus1.dbg_state_o, ST_IDLE);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [DECO_FRAME_W-1:0] f;
    logic [DECO_BEAT_W-1:0]  eb;
    int gap;
    bit ok;
    do_reset();
    f = 84'h123456789ABCDEF012345;
    res_q.push_back(5'b10110);
    exp_q.push_back({1'b0, 5'b10110});
    send_frame1(f, gap, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL single_accept: got no accept, required accept"); end
    for (int k = 0; k < DECO_BEATS; k++) begin
      @(negedge clk);
      eb = f[k*DECO_BEAT_W +: DECO_BEAT_W];
      tests_run++;
      if (start1 !== 1'b1 || data1 !== eb) begin
        tests_failed++;
        $display("FAIL single_beat%0d: got start=%0b data=%h, required start=1 data=%h", k, start1, data1, eb);
      end
    end
    wait_res1(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL single_res_wait: got no res_valid, required res_valid"); end
    tests_run++;
    if (bus1.res_data_o !== 5'b10110 || bus1.res_timeout_o !== 1'b0 || cnt1 !== 16'd1 || start1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_result: got data=%b to=%0b cnt=%0d start=%0b, required data=10110 to=0 cnt=1 start=0",
               bus1.res_data_o, bus1.res_timeout_o, cnt1, start1);
    end
    wait_drain(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL single_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [DECO_FRAME_W-1:0] f;
    logic [DECO_RES_W-1:0]   r;
    int gap;
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      f = rand_frame();
      r = DECO_RES_W'($urandom_range(0, 31));
      res_q.push_back(r);
      exp_q.push_back({1'b0, r});
      send_frame1(f, gap, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL b2b_accept%0d: got no accept, required accept", i); end
      if (i > 0) begin
        tests_run++;
        if (gap !== 1) begin
          tests_failed++;
          $display("FAIL b2b_gap%0d: got %0d start-low cycles, required 1", i, gap);
        end
      end
    end
    wait_drain(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
    tests_run++;
    if (cnt1 !== 16'd3) begin tests_failed++; $display("FAIL b2b_frame_cnt: got %0d, required 3", cnt1); end
  endtask

  task automatic test_backpressure();
    logic [DECO_FRAME_W-1:0] fa, fb;
    logic [DECO_RES_W-1:0]   r;
    int gap;
    bit ok, stall_ok;
    do_reset();
    bus1.res_ready_i = 1'b0;
    fa = rand_frame();
    r  = DECO_RES_W'($urandom_range(0, 31));
    res_q.push_back(r);
    exp_q.push_back({1'b0, r});
    send_frame1(fa, gap, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL bp_accept_a: got no accept, required accept"); end
    wait_res1(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL bp_res_wait: got no res_valid, required res_valid"); end
    @(posedge clk);
    #1;
    fb = rand_frame();
    r  = DECO_RES_W'($urandom_range(0, 31));
    res_q.push_back(r);
    exp_q.push_back({1'b0, r});
    bus1.frm_valid_i = 1'b1;
    bus1.frm_data_i  = fb;
    stall_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus1.frm_ready_o !== 1'b0 || start1 !== 1'b0 || bus1.res_valid_o !== 1'b1) stall_ok = 1'b0;
    end
    tests_run++;
    if (!stall_ok) begin
      tests_failed++;
      $display("FAIL bp_stall: got frm_ready=%0b start=%0b rv=%0b, required 0 0 1",
               bus1.frm_ready_o, start1, bus1.res_valid_o);
    end
    @(posedge clk);
    #1 bus1.res_ready_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus1.frm_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release_ready: got %0b, required 1", bus1.frm_ready_o);
    end
    @(posedge clk);
    #1 bus1.frm_valid_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (start1 !== 1'b1 || data1 !== fb[DECO_BEAT_W-1:0] || bus1.res_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_launch: got start=%0b data=%h rv=%0b, required start=1 data=%h rv=0",
               start1, data1, bus1.res_valid_o, fb[DECO_BEAT_W-1:0]);
    end
    wait_drain(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size()); end
    tests_run++;
    if (cnt1 !== 16'd2) begin tests_failed++; $display("FAIL bp_frame_cnt: got %0d, required 2", cnt1); end
  endtask

  task automatic test_timeout();
    logic [DECO_FRAME_W-1:0] f;
    int  k;
    bit  ok;
    do_reset();
    f = rand_frame();
    send_frame2(f, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL to_accept: got no accept, required accept"); end
    k = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus2.res_valid_o) begin k = i; break; end
    end
    // 3 cycles to reach WAIT, then TO_SHORT WAIT cycles.
    tests_run++;
    if (k !== 3 + TO_SHORT) begin
      tests_failed++;
      $display("FAIL to_latency: got res_valid at cycle %0d, required %0d", k, 3 + TO_SHORT);
    end
    tests_run++;
    if (bus2.res_timeout_o !== 1'b1 || bus2.res_data_o !== '0 || start2 !== 1'b0 || cnt2 !== 16'd1 ||
        bus2.dbg_state_o !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL to_result: got to=%0b data=%b start=%0b cnt=%0d state=%0d, required 1 0 0 1 %0d",
               bus2.res_timeout_o, bus2.res_data_o, start2, cnt2, bus2.dbg_state_o, ST_IDLE);
    end
    @(posedge clk);
    #1;
    f = rand_frame();
    send_frame2(f, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL to_next_accept: got no accept, required accept"); end
    repeat (4) @(posedge clk);
    #1 begin done2 = 1'b1; dres2 = 5'b01011; end
    @(posedge clk);
    #1 done2 = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus2.res_valid_o !== 1'b1 || bus2.res_data_o !== 5'b01011 || bus2.res_timeout_o !== 1'b0 || cnt2 !== 16'd2) begin
      tests_failed++;
      $display("FAIL to_next_result: got rv=%0b data=%b to=%0b cnt=%0d, required 1 01011 0 2",
               bus2.res_valid_o, bus2.res_data_o, bus2.res_timeout_o, cnt2);
    end
  endtask

  task automatic test_done_at_tc();
    logic [DECO_FRAME_W-1:0] f;
    bit ok;
    do_reset();
    f = rand_frame();
    send_frame2(f, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL tc_accept: got no accept, required accept"); end
    // Edge 3+TO_SHORT after accept is the terminal-count edge.
    repeat (2 + TO_SHORT) @(posedge clk);
    #1 begin done2 = 1'b1; dres2 = 5'b11001; end
    @(negedge clk);
    tests_run++;
    if (bus2.res_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL tc_not_early: got rv=%0b, required 0", bus2.res_valid_o);
    end
    @(posedge clk);
    #1 done2 = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus2.res_valid_o !== 1'b1 || bus2.res_timeout_o !== 1'b0 || bus2.res_data_o !== 5'b11001) begin
      tests_failed++;
      $display("FAIL tc_done_wins: got rv=%0b to=%0b data=%b, required 1 0 11001",
               bus2.res_valid_o, bus2.res_timeout_o, bus2.res_data_o);
    end
  endtask

  task automatic test_mid_reset();
    logic [DECO_FRAME_W-1:0] f;
    int  gap;
    bit  ok, quiet;
    do_reset();
    f = rand_frame();
    res_q.push_back(5'b00111);
    send_frame1(f, gap, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL mr_accept: got no accept, required accept"); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (data1 !== f[2*DECO_BEAT_W +: DECO_BEAT_W]) begin
      tests_failed++;
      $display("FAIL mr_beat2: got %h, required %h", data1, f[2*DECO_BEAT_W +: DECO_BEAT_W]);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    res_q.delete();
    @(negedge clk);
    tests_run++;
    if ({start1, data1, bus1.res_valid_o, bus1.res_data_o, bus1.res_timeout_o} !== '0 ||
        bus1.frm_ready_o !== 1'b1 || cnt1 !== 16'd0) begin
      tests_failed++;
      $display("FAIL mr_outputs: got start=%0b data=%h rv=%0b ready=%0b cnt=%0d, required 0 0 0 1 0",
               start1, data1, bus1.res_valid_o, bus1.frm_ready_o, cnt1);
    end
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus1.res_valid_o !== 1'b0 || start1 !== 1'b0) quiet = 1'b0;
    end
    tests_run++;
    if (!quiet) begin
      tests_failed++;
      $display("FAIL mr_no_result: got rv=%0b start=%0b, required both 0", bus1.res_valid_o, start1);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_done_at_tc();
    test_mid_reset();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL final_queue: got %0d pending results, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    tests_failed++;
    $display("FAIL global_timeout: got no finish after 200000 time units, required finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "global timeout");
  end

endmodule
